// File: rtl/huff_pkg.sv
// Shared Huffman-encoder definitions: default widths and the stage FSM encoding.
package huff_pkg;

    localparam int DEF_SYM_W = 8;
    localparam int NUM_SYM   = 2 ** DEF_SYM_W;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_DRAIN,
        ST_DUMP,
        ST_DONE
    } huff_state_t;

endpackage

// File: rtl/freq_count_if.sv
// Symbol-in / (symbol,count)-out handshake bundle of the histogram stage.
interface freq_count_if
    import huff_pkg::*;
#(
    parameter int SYM_W = DEF_SYM_W,
    parameter int CNT_W = DEF_CNT_W
);

    logic             start;
    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             sym_last;
    logic             sym_ready;
    logic             freq_valid;
    logic [SYM_W-1:0] freq_sym;
    logic [CNT_W-1:0] freq_cnt;
    logic             freq_last;
    logic             freq_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, sym_valid, sym_data, sym_last, freq_ready,
        input  sym_ready, freq_valid, freq_sym, freq_cnt, freq_last, busy, done
    );

    modport slave (
        input  start, sym_valid, sym_data, sym_last, freq_ready,
        output sym_ready, freq_valid, freq_sym, freq_cnt, freq_last, busy, done
    );

endinterface

// File: rtl/freq_count_ram.sv
// Count table: simple dual-port RAM, one write port and a registered read port.
module freq_ram
    import huff_pkg::*;
#(
    parameter int AW = DEF_SYM_W,
    parameter int DW = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/freq_count.sv
// Symbol-frequency histogram: clear table, count symbols by read-modify-write,
// then stream every (symbol, count) pair in symbol order.
module freq_count
    import huff_pkg::*;
#(
    parameter int SYM_W = DEF_SYM_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    freq_count_if.slave  bus
);

    localparam logic [SYM_W-1:0] LAST_ADDR = '1;

    huff_state_t state, state_nxt;

    logic             sym_rdy, busy_o, done_o;
    logic             accept, take;
    logic [SYM_W-1:0] addr;
    logic             pend;

    logic             s1_valid;
    logic [SYM_W-1:0] s1_sym;
    logic             s1_fwd;
    logic [CNT_W-1:0] s1_fwd_val;
    logic [CNT_W-1:0] old_cnt, wr_val;

    logic             ram_we;
    logic [SYM_W-1:0] ram_waddr, ram_raddr;
    logic [CNT_W-1:0] ram_wdata, ram_rdata;

    logic             out_valid, out_last;
    logic [SYM_W-1:0] out_sym;
    logic [CNT_W-1:0] out_cnt;

    freq_ram #(.AW(SYM_W), .DW(CNT_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (addr == LAST_ADDR) state_nxt = ST_COUNT;
            ST_COUNT: if (accept && bus.sym_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!s1_valid) state_nxt = ST_DUMP;
            ST_DUMP:  if (out_valid && bus.freq_ready && out_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sym_rdy = (state == ST_COUNT);
        busy_o  = (state != ST_IDLE);
        done_o  = (state == ST_DONE);
    end

    // Write-stage value comes from the forward register when the previous
    // cycle's read raced the write of the same entry.
    always_comb begin
        accept  = bus.sym_valid && sym_rdy;
        old_cnt = s1_fwd ? s1_fwd_val : ram_rdata;
        wr_val  = (old_cnt == '1) ? old_cnt : old_cnt + 1'b1;
        take    = (state == ST_DUMP) && pend && (!out_valid || bus.freq_ready);

        ram_we    = (state == ST_CLEAR) || s1_valid;
        ram_waddr = (state == ST_CLEAR) ? addr : s1_sym;
        ram_wdata = (state == ST_CLEAR) ? '0 : wr_val;
        if (state == ST_DUMP) begin
            ram_raddr = take ? addr + 1'b1 : addr;
        end else begin
            ram_raddr = bus.sym_data;
        end
    end

    // During DUMP, addr names the entry now on the RAM output; while stalled
    // it is re-read so the read data stays put without a skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            pend       <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sym     <= '0;
            s1_fwd     <= 1'b0;
            s1_fwd_val <= '0;
            out_valid  <= 1'b0;
            out_sym    <= '0;
            out_cnt    <= '0;
            out_last   <= 1'b0;
        end else begin
            s1_valid   <= accept;
            s1_sym     <= bus.sym_data;
            s1_fwd     <= accept && s1_valid && (bus.sym_data == s1_sym);
            s1_fwd_val <= wr_val;

            case (state)
                ST_IDLE:  addr <= '0;
                ST_CLEAR: addr <= addr + 1'b1;
                ST_DUMP:  if (take && addr != LAST_ADDR) addr <= addr + 1'b1;
                default:  ;
            endcase

            if (state == ST_DUMP) begin
                if (take) begin
                    pend <= (addr != LAST_ADDR);
                end else if (!pend && !(out_valid && out_last)) begin
                    pend <= 1'b1;
                end
            end else begin
                pend <= 1'b0;
            end

            if (take) begin
                out_valid <= 1'b1;
                out_sym   <= addr;
                out_cnt   <= ram_rdata;
                out_last  <= (addr == LAST_ADDR);
            end else if (bus.freq_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.sym_ready  = sym_rdy;
    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.freq_valid = out_valid;
    assign bus.freq_sym   = out_sym;
    assign bus.freq_cnt   = out_cnt;
    assign bus.freq_last  = out_last;

endmodule

// File: tb/tb_freq_count.sv
// Self-checking bench: two histogram instances (16-bit and 4-bit counts) run in
// lockstep against a symbol-count model.
module tb_freq_count;
    import huff_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, sym_valid = 1'b0, sym_last = 1'b0, freq_ready = 1'b1;
    logic [7:0] sym_data = '0;
    bit         rdy_rand = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    freq_count_if #(.SYM_W(8), .CNT_W(16)) if16 ();
    freq_count_if #(.SYM_W(8), .CNT_W(4))  if4 ();

    assign if16.start = start;       assign if4.start = start;
    assign if16.sym_valid = sym_valid; assign if4.sym_valid = sym_valid;
    assign if16.sym_data = sym_data; assign if4.sym_data = sym_data;
    assign if16.sym_last = sym_last; assign if4.sym_last = sym_last;
    assign if16.freq_ready = freq_ready; assign if4.freq_ready = freq_ready;

    freq_count #(.SYM_W(8), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    freq_count #(.SYM_W(8), .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    // Model: raw occurrence counts of the current block
    int unsigned hist [NUM_SYM];
    logic [7:0]  q [$];

    int         got [2][NUM_SYM];
    int         exp_idx [2];
    int         xfers [2];
    bit         stall [2];
    bit         done_due [2];
    logic [7:0] psym [2];
    int         pcnt [2];
    logic       plast [2];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input int w, input logic st, input logic bsy, input logic fv,
                       input logic [7:0] fs, input int fc, input logic fl, input logic fr,
                       input logic dn, input logic sr, input int maxc);
        int e;
        if (st && !bsy) begin
            exp_idx[w] = 0;
            xfers[w]   = 0;
            for (int i = 0; i < NUM_SYM; i++) got[w][i] = 0;
        end
        chk($sformatf("done_pulse[%0d]", w), dn, done_due[w]);
        done_due[w] = 1'b0;
        if (fv) begin
            if (exp_idx[w] < NUM_SYM) begin
                e = (hist[exp_idx[w]] > maxc) ? maxc : int'(hist[exp_idx[w]]);
                chk($sformatf("pair_sym[%0d]", w), fs, exp_idx[w]);
                chk($sformatf("pair_cnt[%0d] sym %0d", w, exp_idx[w]), fc, e);
                chk($sformatf("pair_last[%0d]", w), fl, exp_idx[w] == NUM_SYM - 1);
            end else begin
                chk($sformatf("pair_beyond_end[%0d]", w), exp_idx[w], NUM_SYM - 1);
            end
            if (stall[w]) begin
                chk($sformatf("hold_sym[%0d]", w), fs, psym[w]);
                chk($sformatf("hold_cnt[%0d]", w), fc, pcnt[w]);
                chk($sformatf("hold_last[%0d]", w), fl, plast[w]);
            end
            chk($sformatf("ready_in_dump[%0d]", w), sr, 0);
        end else if (stall[w]) begin
            chk($sformatf("valid_dropped[%0d]", w), fv, 1);
        end
        stall[w] = fv && !fr;
        psym[w]  = fs;
        pcnt[w]  = fc;
        plast[w] = fl;
        if (fv && fr) begin
            if (exp_idx[w] < NUM_SYM) got[w][exp_idx[w]] = fc;
            xfers[w]++;
            exp_idx[w]++;
            if (fl) done_due[w] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++) begin
                stall[w]    = 1'b0;
                done_due[w] = 1'b0;
                exp_idx[w]  = 0;
            end
        end else begin
            mon(0, start, if16.busy, if16.freq_valid, if16.freq_sym, int'(if16.freq_cnt),
                if16.freq_last, freq_ready, if16.done, if16.sym_ready, 65535);
            mon(1, start, if4.busy, if4.freq_valid, if4.freq_sym, int'(if4.freq_cnt),
                if4.freq_last, freq_ready, if4.done, if4.sym_ready, 15);
        end
    end

    always @(posedge clk) begin
        #1;
        freq_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sym_ready"}, if16.sym_ready, 0);
        chk({tag, "_freq_valid"}, if16.freq_valid, 0);
        chk({tag, "_freq_last"}, if16.freq_last, 0);
        chk({tag, "_busy"}, if16.busy, 0);
        chk({tag, "_done"}, if16.done, 0);
        chk({tag, "_freq_sym"}, if16.freq_sym, 0);
        chk({tag, "_freq_cnt"}, if16.freq_cnt, 0);
        chk({tag, "_busy4"}, if4.busy, 0);
        chk({tag, "_freq_cnt4"}, if4.freq_cnt, 0);
    endtask

    task automatic pulse_start_and_wait_ready(input bit noise, output int cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (if16.sym_ready) break;
            if (noise && cyc < 200) begin
                sym_valid = 1'($urandom_range(0, 1));
                sym_data  = 8'($urandom);
                sym_last  = 1'($urandom_range(0, 1));
            end else begin
                sym_valid = 1'b0;
                sym_last  = 1'b0;
            end
        end
    endtask

    task automatic run_block(input bit gaps, input bit noise, input bit pokes);
        int cyc, waitc, n;
        n = q.size();
        for (int i = 0; i < NUM_SYM; i++) hist[i] = 0;
        foreach (q[i]) hist[q[i]]++;

        pulse_start_and_wait_ready(noise, cyc);
        chk("clear_latency", cyc, 257);
        chk("ready_lockstep", if4.sym_ready, 1);

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    sym_valid = 1'b0;
                    @(negedge clk);
                end
            end
            sym_valid = 1'b1;
            sym_data  = q[i];
            sym_last  = (i == n - 1);
            start     = pokes && (i == n / 2);
            waitc = 0;
            while (!if16.sym_ready && waitc < 100) begin
                @(negedge clk);
                waitc++;
            end
            if (waitc >= 100) chk("sym_accept_timeout", waitc, 0);
            @(negedge clk);
            start = 1'b0;
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        chk("ready_after_last", if16.sym_ready, 0);

        cyc = 0;
        while (!if16.done && cyc < 3000) begin
            if (noise) begin
                sym_valid = 1'b1;
                sym_data  = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
            start = pokes && (cyc % 37 == 5);
        end
        start = 1'b0;
        sym_valid = 1'b0;
        chk("done_seen", if16.done, 1);
        @(negedge clk);
        chk("busy_after_done", if16.busy, 0);
        chk("done_width", if16.done, 0);
        chk("pairs16", xfers[0], NUM_SYM);
        chk("pairs4", xfers[1], NUM_SYM);
    endtask

    initial begin
        int sum;
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum, n, alpha;
        int cyc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // basic block
        q = '{8'h00, 8'h01, 8'h01, 8'hFF};
        run_block(0, 0, 0);
        chk("t1_cnt0", got[0][0], 1);
        chk("t1_cnt1", got[0][1], 2);
        chk("t1_cnt255", got[0][255], 1);
        chk("t1_cnt2", got[0][2], 0);

        // long run of one symbol: forwarding every cycle
        q.delete();
        repeat (1000) q.push_back(8'h41);
        run_block(0, 0, 0);
        chk("t2_cnt41", got[0][8'h41], 1000);
        chk("t2_cnt41_sat", got[1][8'h41], 15);

        // saturation on the narrow instance
        q.delete();
        repeat (20) q.push_back(8'h10);
        run_block(0, 0, 0);
        chk("t3_sat4", got[1][8'h10], 15);
        chk("t3_wide", got[0][8'h10], 20);

        // single-symbol block
        q = '{8'h5A};
        rdy_rand = 1'b1;
        run_block(0, 0, 0);
        chk("single_cnt", got[0][8'h5A], 1);

        // randomized blocks with stalls and gaps
        for (int b = 0; b < 5; b++) begin
            q.delete();
            n = $urandom_range(1, 300);
            alpha = (b % 2 == 0) ? 3 : 255;
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, alpha)));
            run_block(b % 2 == 1, 0, 0);
        end
        rdy_rand = 1'b0;

        // reset in the middle of COUNT, then a fresh block
        pulse_start_and_wait_ready(0, cyc);
        for (int i = 0; i < 20; i++) begin
            sym_valid = 1'b1;
            sym_data  = 8'h7F + 8'(i % 3);
            @(negedge clk);
        end
        rst = 1'b1;
        sym_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        q = '{8'h7F, 8'h7F, 8'h7F};
        run_block(0, 0, 0);
        chk("t5_cnt7f", got[0][8'h7F], 3);
        sum = 0;
        for (int i = 0; i < NUM_SYM; i++) if (i != 8'h7F) sum += got[0][i];
        chk("t5_others", sum, 0);

        // start while busy and symbols outside COUNT are ignored
        q = '{8'h22, 8'h22, 8'h33, 8'h22, 8'h22, 8'h33, 8'h22};
        rdy_rand = 1'b1;
        run_block(1, 1, 1);
        rdy_rand = 1'b0;
        chk("t6_cnt22", got[0][8'h22], 5);
        chk("t6_cnt33", got[0][8'h33], 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
